// File: rtl/health_control.sv
// -----------------------------------------------------------------------------
// health_control
//
// Round/health bookkeeping for a two-player fighting game.  Tracks each
// player's health, applies damage from rising edges of the hit/block levels
// coming out of the punch logic, enforces a per-player invulnerability
// window after every accepted hit or block, and runs the round FSM
// IDLE -> FIGHT -> KO_HOLD -> DONE.
//
// Parameters
//   MAX_HEALTH     starting and maximum health per player (must fit 7 bits)
//   HIT_DAMAGE     health removed per accepted unblocked hit
//   BLOCK_DAMAGE   chip health removed per accepted block
//   INVULN_FRAMES  frames a player ignores hits/blocks after one is accepted
//   KO_HOLD_FRAMES frames spent in KO_HOLD before DONE
//
// Ports
//   frame_clk            frame clock, all state changes on its rising edge
//   Reset                asynchronous active-low reset
//   round_start          one-frame pulse that starts or restarts a round
//   hitP1/hitP2          hit levels (may stay high for several frames)
//   blockP1/blockP2      block levels (may stay high for several frames)
//   healthP1/healthP2    current health, unsigned 7 bits
//   stunP1/stunP2        high while that player's invulnerability runs
//   fight_active         high only in FIGHT
//   round_over           high in KO_HOLD and DONE
//   winnerP1/winnerP2    round result while round_over is high; both low = draw
// -----------------------------------------------------------------------------
module health_control #(
    parameter int MAX_HEALTH     = 100,
    parameter int HIT_DAMAGE     = 10,
    parameter int BLOCK_DAMAGE   = 2,
    parameter int INVULN_FRAMES  = 30,
    parameter int KO_HOLD_FRAMES = 120
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       round_start,
    input  logic       hitP1,
    input  logic       hitP2,
    input  logic       blockP1,
    input  logic       blockP2,
    output logic [6:0] healthP1,
    output logic [6:0] healthP2,
    output logic       stunP1,
    output logic       stunP2,
    output logic       fight_active,
    output logic       round_over,
    output logic       winnerP1,
    output logic       winnerP2
);

    // Widths: the stun counter must hold INVULN_FRAMES, the KO counter must
    // hold KO_HOLD_FRAMES and is never narrower than 8 bits.
    localparam int STUN_W   = (INVULN_FRAMES < 1) ? 1 : $clog2(INVULN_FRAMES + 1);
    localparam int KO_W_MIN = $clog2(KO_HOLD_FRAMES + 1);
    localparam int KO_W     = (KO_W_MIN < 8) ? 8 : KO_W_MIN;

    localparam logic [6:0]        MAX_H     = 7'(MAX_HEALTH);
    localparam logic [6:0]        HIT_D     = 7'(HIT_DAMAGE);
    localparam logic [6:0]        BLOCK_D   = 7'(BLOCK_DAMAGE);
    localparam logic [STUN_W-1:0] STUN_LOAD = STUN_W'(INVULN_FRAMES);
    localparam logic [KO_W-1:0]   KO_LAST   = KO_W'(KO_HOLD_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FIGHT   = 2'd1,
        KO_HOLD = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state_reg;

    // Index 0 is player 1, index 1 is player 2 throughout.
    logic [1:0]             hit_cur_reg;
    logic [1:0]             hit_prev_reg;
    logic [1:0]             block_cur_reg;
    logic [1:0]             block_prev_reg;
    logic [1:0][6:0]        health_reg;
    logic [1:0][STUN_W-1:0] stun_reg;
    logic [KO_W-1:0]        ko_cnt_reg;
    logic [1:0]             winner_reg;
    logic                   fight_active_reg;
    logic                   round_over_reg;

    logic [1:0]             hit_evt;
    logic [1:0]             block_evt;
    logic [1:0]             accept;
    logic [1:0][6:0]        damage;
    logic [1:0][6:0]        health_next;
    logic [1:0][STUN_W-1:0] stun_dec;
    logic [1:0][STUN_W-1:0] stun_next;
    logic                   any_ko;

    logic [1:0] hit_lvl;
    logic [1:0] block_lvl;

    assign hit_lvl   = {hitP2, hitP1};
    assign block_lvl = {blockP2, blockP1};

    // Per-player event detection and damage arithmetic.  The levels are
    // sampled into *_cur_reg every frame and the previous sample is kept in
    // *_prev_reg, so an event is visible for exactly one frame and is applied
    // at the following edge.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_player
            assign hit_evt[gi]   = hit_cur_reg[gi] & ~hit_prev_reg[gi];
            assign block_evt[gi] = block_cur_reg[gi] & ~block_prev_reg[gi];

            // A stunned player discards events outright; nothing is queued.
            assign accept[gi] = (stun_reg[gi] == '0) && (hit_evt[gi] || block_evt[gi]);

            // Hit wins over a simultaneous block.
            assign damage[gi] = hit_evt[gi] ? HIT_D : BLOCK_D;

            assign stun_dec[gi] = (stun_reg[gi] == '0) ? '0 : stun_reg[gi] - STUN_W'(1);

            // Saturating subtract: health bottoms out at zero.
            assign health_next[gi] = !accept[gi]                  ? health_reg[gi] :
                                     (health_reg[gi] > damage[gi]) ? health_reg[gi] - damage[gi] :
                                                                    7'd0;

            assign stun_next[gi] = accept[gi] ? STUN_LOAD : stun_dec[gi];
        end
    endgenerate

    assign any_ko = (health_reg[0] == 7'd0) || (health_reg[1] == 7'd0);

    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            state_reg        <= IDLE;
            hit_cur_reg      <= '0;
            hit_prev_reg     <= '0;
            block_cur_reg    <= '0;
            block_prev_reg   <= '0;
            health_reg[0]    <= MAX_H;
            health_reg[1]    <= MAX_H;
            stun_reg         <= '0;
            ko_cnt_reg       <= '0;
            winner_reg       <= '0;
            fight_active_reg <= 1'b0;
            round_over_reg   <= 1'b0;
        end else begin
            // Edge history runs in every state, so a level that was already
            // high before the round begins never shows up as an event.
            hit_cur_reg    <= hit_lvl;
            hit_prev_reg   <= hit_cur_reg;
            block_cur_reg  <= block_lvl;
            block_prev_reg <= block_cur_reg;

            if (round_start) begin
                // Start or restart from any state.
                state_reg        <= FIGHT;
                health_reg[0]    <= MAX_H;
                health_reg[1]    <= MAX_H;
                stun_reg         <= '0;
                ko_cnt_reg       <= '0;
                winner_reg       <= '0;
                fight_active_reg <= 1'b1;
                round_over_reg   <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        fight_active_reg <= 1'b0;
                        round_over_reg   <= 1'b0;
                    end

                    FIGHT: begin
                        if (any_ko) begin
                            // A health hit zero last frame: freeze healths,
                            // latch the result and start the KO hold.
                            state_reg        <= KO_HOLD;
                            ko_cnt_reg       <= '0;
                            stun_reg         <= stun_dec;
                            winner_reg[0]    <= (health_reg[1] == 7'd0) && (health_reg[0] != 7'd0);
                            winner_reg[1]    <= (health_reg[0] == 7'd0) && (health_reg[1] != 7'd0);
                            fight_active_reg <= 1'b0;
                            round_over_reg   <= 1'b1;
                        end else begin
                            health_reg <= health_next;
                            stun_reg   <= stun_next;
                        end
                    end

                    KO_HOLD: begin
                        // Counter holds 0..KO_HOLD_FRAMES-1, one value per
                        // frame spent here.
                        if (ko_cnt_reg == KO_LAST) begin
                            state_reg <= DONE;
                        end else begin
                            ko_cnt_reg <= ko_cnt_reg + KO_W'(1);
                        end
                    end

                    DONE: begin
                        fight_active_reg <= 1'b0;
                        round_over_reg   <= 1'b1;
                    end

                    default: begin
                        state_reg        <= IDLE;
                        fight_active_reg <= 1'b0;
                        round_over_reg   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign healthP1     = health_reg[0];
    assign healthP2     = health_reg[1];
    assign stunP1       = (stun_reg[0] != '0);
    assign stunP2       = (stun_reg[1] != '0);
    assign fight_active = fight_active_reg;
    assign round_over   = round_over_reg;
    assign winnerP1     = winner_reg[0];
    assign winnerP2     = winner_reg[1];

endmodule

// File: tb/tb_health_control.sv
module tb_health_control;

    logic frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    logic Reset;

    // Instance 0: default parameters.  Instance 1: HIT_DAMAGE = 60.
    logic            rs0, rs1;
    logic [1:0]      hit0, blk0, hit1, blk1;
    logic [1:0][6:0] hp0, hp1;
    logic [1:0]      stun0, stun1, win0, win1;
    logic            fa0, fa1, ro0, ro1;

    health_control dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .round_start (rs0),
        .hitP1       (hit0[0]),
        .hitP2       (hit0[1]),
        .blockP1     (blk0[0]),
        .blockP2     (blk0[1]),
        .healthP1    (hp0[0]),
        .healthP2    (hp0[1]),
        .stunP1      (stun0[0]),
        .stunP2      (stun0[1]),
        .fight_active(fa0),
        .round_over  (ro0),
        .winnerP1    (win0[0]),
        .winnerP2    (win0[1])
    );

    health_control #(.HIT_DAMAGE(60)) dut_sat (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .round_start (rs1),
        .hitP1       (hit1[0]),
        .hitP2       (hit1[1]),
        .blockP1     (blk1[0]),
        .blockP2     (blk1[1]),
        .healthP1    (hp1[0]),
        .healthP2    (hp1[1]),
        .stunP1      (stun1[0]),
        .stunP2      (stun1[1]),
        .fight_active(fa1),
        .round_over  (ro1),
        .winnerP1    (win1[0]),
        .winnerP2    (win1[1])
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- behavioural reference model ----------------
    localparam int M_IDLE = 0, M_FIGHT = 1, M_KO = 2, M_DONE = 3;
    int         m_phase [2];
    int         m_h     [2][2];
    int         m_stun  [2][2];   // frames of invulnerability left
    int         m_win   [2][2];
    int         m_ko_frames [2];  // frames already spent holding the KO
    logic [3:0] seen_now [2];     // last sampled levels {blk2,blk1,hit2,hit1}
    logic [3:0] seen_old [2];     // the sample before that

    function automatic void model_reset(input int i);
        m_phase[i] = M_IDLE;
        m_ko_frames[i] = 0;
        seen_now[i] = 4'b0;
        seen_old[i] = 4'b0;
        for (int p = 0; p < 2; p++) begin
            m_h[i][p] = 100;
            m_stun[i][p] = 0;
            m_win[i][p] = 0;
        end
    endfunction

    function automatic void model_step(input int i, input logic rs, input logic [3:0] lv);
        int  hit_dmg;
        bit  someone_down;
        bit  ev_hit, ev_blk, was_free;
        hit_dmg = (i == 0) ? 10 : 60;
        if (rs) begin
            m_phase[i] = M_FIGHT;
            m_ko_frames[i] = 0;
            for (int p = 0; p < 2; p++) begin
                m_h[i][p] = 100;
                m_stun[i][p] = 0;
                m_win[i][p] = 0;
            end
        end else if (m_phase[i] == M_FIGHT) begin
            someone_down = (m_h[i][0] == 0) || (m_h[i][1] == 0);
            if (someone_down) begin
                m_phase[i] = M_KO;
                m_ko_frames[i] = 0;
                m_win[i][0] = (m_h[i][1] == 0 && m_h[i][0] != 0) ? 1 : 0;
                m_win[i][1] = (m_h[i][0] == 0 && m_h[i][1] != 0) ? 1 : 0;
            end
            for (int p = 0; p < 2; p++) begin
                ev_hit   = seen_now[i][p] && !seen_old[i][p];
                ev_blk   = seen_now[i][2+p] && !seen_old[i][2+p];
                was_free = (m_stun[i][p] == 0);
                if (m_stun[i][p] > 0) m_stun[i][p] = m_stun[i][p] - 1;
                if (!someone_down && was_free && (ev_hit || ev_blk)) begin
                    m_h[i][p] = m_h[i][p] - (ev_hit ? hit_dmg : 2);
                    if (m_h[i][p] < 0) m_h[i][p] = 0;
                    m_stun[i][p] = 30;
                end
            end
        end else if (m_phase[i] == M_KO) begin
            m_ko_frames[i] = m_ko_frames[i] + 1;
            if (m_ko_frames[i] == 120) m_phase[i] = M_DONE;
        end
        seen_old[i] = seen_now[i];
        seen_now[i] = lv;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        logic [6:0] h_obs;
        logic       s_obs, w_obs, fa_obs, ro_obs;
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 2; p++) begin
                h_obs = (i == 0) ? hp0[p]   : hp1[p];
                s_obs = (i == 0) ? stun0[p] : stun1[p];
                w_obs = (i == 0) ? win0[p]  : win1[p];
                check($sformatf("model_health_i%0d_p%0d", i, p + 1), 32'(h_obs), 32'(m_h[i][p]));
                check($sformatf("model_stun_i%0d_p%0d", i, p + 1), 32'(s_obs), 32'(m_stun[i][p] != 0));
                check($sformatf("model_winner_i%0d_p%0d", i, p + 1), 32'(w_obs), 32'(m_win[i][p]));
            end
            fa_obs = (i == 0) ? fa0 : fa1;
            ro_obs = (i == 0) ? ro0 : ro1;
            check($sformatf("model_fight_active_i%0d", i), 32'(fa_obs), 32'(m_phase[i] == M_FIGHT));
            check($sformatf("model_round_over_i%0d", i), 32'(ro_obs),
                  32'(m_phase[i] == M_KO || m_phase[i] == M_DONE));
        end
    endtask

    // One frame: advance both models at the edge, compare 1 time unit later.
    task automatic tick();
        @(posedge frame_clk);
        if (!Reset) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0, rs0, {blk0, hit0});
            model_step(1, rs1, {blk1, hit1});
        end
        #1;
        compare_all();
    endtask

    // Reset pulsed low between edges; outputs must be at reset values at once.
    task automatic reset_pulse();
        Reset = 1'b0;
        #1;
        model_reset(0);
        model_reset(1);
        compare_all();
        #2;
        Reset = 1'b1;
    endtask

    int stun_frames;

    initial begin
        Reset = 1'b0;
        rs0 = 1'b0; rs1 = 1'b0;
        hit0 = '0; blk0 = '0; hit1 = '0; blk1 = '0;
        model_reset(0);
        model_reset(1);

        // Reset state
        repeat (3) tick();
        check("reset_healthP1", 32'(hp0[0]), 32'd100);
        check("reset_healthP2", 32'(hp0[1]), 32'd100);
        check("reset_fight_active", 32'(fa0), 32'd0);
        check("reset_round_over", 32'(ro0), 32'd0);
        #2 Reset = 1'b1;
        repeat (3) tick();
        check("idle_holds_fight_active", 32'(fa0), 32'd0);

        // Clean hit on P2, level held for 5 frames
        rs0 = 1'b1; tick(); rs0 = 1'b0;
        check("start_fight_active", 32'(fa0), 32'd1);
        hit0[1] = 1'b1;
        tick();
        check("clean_hit_latency", 32'(hp0[1]), 32'd100);
        tick();
        check("clean_hit_healthP2", 32'(hp0[1]), 32'd90);
        stun_frames = stun0[1] ? 1 : 0;
        for (int k = 0; k < 40; k++) begin
            if (k == 3) hit0[1] = 1'b0;
            tick();
            if (stun0[1]) stun_frames++;
        end
        check("clean_hit_stun_frames", 32'(stun_frames), 32'd30);
        check("clean_hit_healthP2_held", 32'(hp0[1]), 32'd90);
        check("clean_hit_healthP1", 32'(hp0[0]), 32'd100);

        // Stun window: edges at frames 0, 10, 31
        rs0 = 1'b1; tick(); rs0 = 1'b0;
        for (int f = 0; f <= 40; f++) begin
            hit0[1] = (f == 0 || f == 1 || f == 10 || f == 11 || f == 31 || f == 32);
            tick();
        end
        hit0[1] = 1'b0;
        tick();
        check("stun_window_healthP2", 32'(hp0[1]), 32'd80);

        // Hit beats simultaneous block; later isolated block chips 2
        rs0 = 1'b1; tick(); rs0 = 1'b0;
        hit0[0] = 1'b1; blk0[0] = 1'b1;
        tick(); tick();
        hit0[0] = 1'b0; blk0[0] = 1'b0;
        tick();
        check("priority_healthP1", 32'(hp0[0]), 32'd90);
        repeat (35) tick();
        blk0[0] = 1'b1;
        tick(); tick();
        blk0[0] = 1'b0;
        check("chip_healthP1", 32'(hp0[0]), 32'd88);

        // Saturation and draw on the HIT_DAMAGE=60 instance
        rs1 = 1'b1; tick(); rs1 = 1'b0;
        hit1 = 2'b11;
        tick(); tick();
        check("sat_first_healthP1", 32'(hp1[0]), 32'd40);
        check("sat_first_healthP2", 32'(hp1[1]), 32'd40);
        hit1 = 2'b00;
        repeat (35) tick();
        hit1 = 2'b11;
        tick(); tick();
        check("sat_healthP1_zero", 32'(hp1[0]), 32'd0);
        check("sat_healthP2_zero", 32'(hp1[1]), 32'd0);
        check("sat_round_over_not_yet", 32'(ro1), 32'd0);
        hit1 = 2'b00;
        tick();
        check("sat_round_over", 32'(ro1), 32'd1);
        check("sat_draw_winners", 32'(win1), 32'd0);
        check("sat_fight_inactive", 32'(fa1), 32'd0);
        repeat (125) tick();
        check("sat_done_round_over", 32'(ro1), 32'd1);
        check("sat_done_health_held", 32'(hp1[0]), 32'd0);

        // Win for P1 after ten spaced hits on P2
        rs0 = 1'b1; tick(); rs0 = 1'b0;
        for (int n = 0; n < 10; n++) begin
            hit0[1] = 1'b1;
            tick(); tick();
            hit0[1] = 1'b0;
            repeat (33) tick();
        end
        check("win_healthP2", 32'(hp0[1]), 32'd0);
        check("win_winnerP1", 32'(win0[0]), 32'd1);
        check("win_winnerP2", 32'(win0[1]), 32'd0);
        check("win_round_over", 32'(ro0), 32'd1);
        repeat (125) tick();
        rs0 = 1'b1; tick(); rs0 = 1'b0;
        check("restart_healthP1", 32'(hp0[0]), 32'd100);
        check("restart_healthP2", 32'(hp0[1]), 32'd100);
        check("restart_winners", 32'(win0), 32'd0);
        check("restart_fight_active", 32'(fa0), 32'd1);

        // Reset mid-fight with a P2 event pending
        hit0[0] = 1'b1;
        tick(); tick();
        check("pre_reset_healthP1", 32'(hp0[0]), 32'd90);
        hit0[1] = 1'b1;
        tick();
        Reset = 1'b0;
        #1;
        model_reset(0);
        model_reset(1);
        check("async_reset_healthP1", 32'(hp0[0]), 32'd100);
        check("async_reset_healthP2", 32'(hp0[1]), 32'd100);
        check("async_reset_fight_active", 32'(fa0), 32'd0);
        check("async_reset_stunP1", 32'(stun0[0]), 32'd0);
        hit0 = '0;
        #2 Reset = 1'b1;
        repeat (5) tick();
        check("post_reset_idle", 32'(fa0), 32'd0);
        check("post_reset_healthP2", 32'(hp0[1]), 32'd100);

        // Randomised play against the model
        for (int n = 0; n < 1500; n++) begin
            rs0 = ($urandom_range(0, 199) == 0);
            rs1 = ($urandom_range(0, 149) == 0);
            if (n == 5) begin rs0 = 1'b1; rs1 = 1'b1; end
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 5) == 0) hit0[p] = ~hit0[p];
                if ($urandom_range(0, 5) == 0) blk0[p] = ~blk0[p];
                if ($urandom_range(0, 7) == 0) hit1[p] = ~hit1[p];
                if ($urandom_range(0, 7) == 0) blk1[p] = ~blk1[p];
            end
            tick();
            if (n == 800) reset_pulse();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/health_control.md
HEALTH_CONTROL -- requirements
Module: health_control

Interface
REQ-001 Parameter MAX_HEALTH, default 100: starting and maximum health per player.
REQ-002 Parameter HIT_DAMAGE, default 10: health removed per accepted unblocked hit.
REQ-003 Parameter BLOCK_DAMAGE, default 2: chip health removed per accepted block.
REQ-004 Parameter INVULN_FRAMES, default 30: frames a player ignores further hits or blocks after one is accepted.
REQ-005 Parameter KO_HOLD_FRAMES, default 120: frames spent in KO_HOLD before DONE.
REQ-006 Port frame_clk, input, 1: frame clock; all state changes on its rising edge.
REQ-007 Port Reset, input, 1: asynchronous, active-low reset.
REQ-008 Port round_start, input, 1: single-frame pulse that starts or restarts a round.
REQ-009 Ports hitP1, hitP2, blockP1, blockP2, inputs, 1 each: hit and block levels from the punch logic; may stay high for several frames.
REQ-010 Ports healthP1, healthP2, outputs, 7 each: current health, unsigned.
REQ-011 Ports stunP1, stunP2, outputs, 1 each: high while that player's invulnerability counter is non-zero.
REQ-012 Port fight_active, output, 1: high only in FIGHT.
REQ-013 Port round_over, output, 1: high in KO_HOLD and DONE.
REQ-014 Ports winnerP1, winnerP2, outputs, 1 each: round result, valid while round_over is high; both low means a draw.

Function
REQ-015 The block SHALL implement an FSM with states IDLE, FIGHT, KO_HOLD and DONE.
REQ-016 Transitions SHALL be:
- IDLE -> FIGHT on round_start.
- FIGHT -> KO_HOLD on the frame after any health register reaches 0.
- KO_HOLD -> DONE after KO_HOLD_FRAMES frames.
- DONE -> FIGHT on round_start.
REQ-017 round_start in FIGHT or KO_HOLD SHALL restart the round: both healths = MAX_HEALTH, stun counters cleared, winners cleared, state = FIGHT.
REQ-018 Entering FIGHT from any state SHALL load both healths with MAX_HEALTH and clear both stun counters.
REQ-019 Each of the four inputs SHALL be registered once per frame; an event is a rising edge (current high, previous low).
- Edge registers SHALL update in every state, so a level already high when FIGHT starts produces no event.
REQ-020 Events SHALL be acted on only in FIGHT, and only for a player whose stun counter is 0; all other events are discarded, not queued.
REQ-021 A hit event and a block event for the same player in the same frame SHALL be treated as a hit only.
REQ-022 An accepted event SHALL take effect on the next frame_clk edge (1-frame latency):
- health -= HIT_DAMAGE for a hit, BLOCK_DAMAGE for a block.
- the stun counter loads INVULN_FRAMES.
REQ-023 Subtraction SHALL saturate at 0; health never wraps and never exceeds MAX_HEALTH.
REQ-024 A non-zero stun counter SHALL decrement by 1 per frame in FIGHT; in KO_HOLD and DONE it holds its value.
REQ-025 Events for P1 and P2 in the same frame SHALL both be applied in that frame, independently.
REQ-026 On entry to KO_HOLD the winners SHALL be latched from the health values:
- P2 health 0 and P1 health non-zero -> winnerP1 = 1.
- P1 health 0 and P2 health non-zero -> winnerP2 = 1.
- both healths 0 -> both winners 0 (draw).
REQ-027 The KO_HOLD frame counter SHALL be at least 8 bits wide; it clears on entry to KO_HOLD.
REQ-028 Healths and winners SHALL hold unchanged in KO_HOLD and DONE until the next round start.

Reset
REQ-029 While Reset is low, regardless of frame_clk, the block SHALL be in this state:
- state = IDLE.
- healthP1 = healthP2 = MAX_HEALTH.
- stun counters, KO counter, edge registers, winners = 0.
- fight_active = round_over = 0.
REQ-030 Reset asserted mid-FIGHT or mid-KO_HOLD SHALL abort immediately with no pending damage applied.
REQ-031 After Reset deasserts, the block SHALL stay in IDLE until round_start.

Verification
REQ-032 Clean hit: round_start, then hitP2 high for 5 frames -> healthP2 = 90 one frame after the edge, stunP2 high for exactly 30 frames, healthP1 = 100.
REQ-033 Stun window: P2 hit edges at frame 0 and frame 10, then at frame 31 -> only the frame-0 and frame-31 hits apply, healthP2 = 80.
REQ-034 Priority and chip damage: hitP1 and blockP1 rise in the same frame -> healthP1 = 90; an isolated blockP1 edge after stun expires -> healthP1 = 88.
REQ-035 Saturation and draw:
- Setup: HIT_DAMAGE = 60; simultaneous P1 and P2 hit edges twice, spaced more than 30 frames apart.
- Response: both healths = 0, round_over goes high one frame later, winners both 0, DONE after 120 frames.
REQ-036 Win and restart:
- Stimulus: ten spaced P2 hits.
- Response: healthP2 = 0 and winnerP1 = 1.
- Then: round_start in DONE gives healths 100/100 with winners cleared.
- Then: Reset pulsed low mid-fight gives IDLE and 100/100 immediately, with no clock edge needed.
